mem_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register.
- Turns load/store control from EX/MEM into a req/ack transaction on the data-memory port.
- Stalls upstream stages while a transaction is outstanding.
- Registers the write-back bundle (MEM/WB) for the WB stage, with bubble insertion and error reporting.

---
 rtl/mem_access_stage_if.sv | 34 +++
 rtl/mem_access_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage.
// Handshake: the stage raises mem_req_o together with mem_we_o, mem_addr_o and
// mem_wdata_o, and holds all four stable until the memory returns a single-cycle
// mem_ack_i pulse (with mem_rdata_i valid in that same cycle for reads). The
// stage may also abandon a request after a timeout. An ack while no request is
// outstanding is ignored.
interface mem_access_stage_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_ack_i;
    logic [31:0]       mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM load/store control into a req/ack memory transaction,
// stalls upstream while it is outstanding, and registers the MEM/WB bundle with
// bubbles during the stall and an error pulse for misaligned or timed-out accesses.
module mem_access_stage #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemWrite_i,
    output logic        stall_o,
    mem_access_stage_if.master mem_if,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] MemData_o,
    output logic [4:0]  RDaddr_o,
    output logic        err_o
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    // Instruction parked while its memory access is in flight
    logic [4:0]        lat_rd_q, lat_rd_d;
    logic              lat_rw_q, lat_rw_d;
    logic              lat_m2r_q, lat_m2r_d;
    logic [31:0]       lat_alu_q, lat_alu_d;
    // MEM/WB register
    logic              rw_q, rw_d;
    logic              m2r_q, m2r_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       md_q, md_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;

    logic access, misaligned, timeout_hit, stall;

    assign access      = MemToReg_i | MemWrite_i;
    assign misaligned  = access & (ALUResult_i[1:0] != 2'b00);
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Next-state, memory-port and MEM/WB update decisions
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_rd_d  = lat_rd_q;
        lat_rw_d  = lat_rw_q;
        lat_m2r_d = lat_m2r_q;
        lat_alu_d = lat_alu_q;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        alu_d     = alu_q;
        md_d      = md_q;
        rd_d      = rd_q;
        err_d     = 1'b0;
        stall     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    stall     = 1'b1;
                    state_d   = S_WAIT;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    we_d      = MemWrite_i;
                    addr_d    = {ALUResult_i[ADDR_W-1:2], 2'b00};
                    wdata_d   = RDData_i;
                    lat_rd_d  = RDaddr_i;
                    lat_rw_d  = RegWrite_i;
                    // a load that is also flagged as a store is a store
                    lat_m2r_d = MemToReg_i & ~MemWrite_i;
                    lat_alu_d = ALUResult_i;
                    rw_d      = 1'b0;
                    m2r_d     = 1'b0;
                end else if (misaligned) begin
                    rw_d  = 1'b0;
                    m2r_d = 1'b0;
                    rd_d  = RDaddr_i;
                    alu_d = ALUResult_i;
                    err_d = 1'b1;
                end else begin
                    rw_d  = RegWrite_i;
                    m2r_d = MemToReg_i;
                    rd_d  = RDaddr_i;
                    alu_d = ALUResult_i;
                end
            end
            S_WAIT: begin
                rd_d  = rd_q;
                if (mem_if.mem_ack_i) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    rw_d    = lat_rw_q;
                    m2r_d   = lat_m2r_q;
                    rd_d    = lat_rd_q;
                    alu_d   = lat_alu_q;
                    if (lat_m2r_q) begin
                        md_d = mem_if.mem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    rw_d    = 1'b0;
                    m2r_d   = 1'b0;
                    rd_d    = lat_rd_q;
                    alu_d   = lat_alu_q;
                    err_d   = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    rw_d  = 1'b0;
                    m2r_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, memory-port and MEM/WB registers; reset abandons any transaction
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_rd_q  <= '0;
            lat_rw_q  <= 1'b0;
            lat_m2r_q <= 1'b0;
            lat_alu_q <= '0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            alu_q     <= '0;
            md_q      <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_rd_q  <= lat_rd_d;
            lat_rw_q  <= lat_rw_d;
            lat_m2r_q <= lat_m2r_d;
            lat_alu_q <= lat_alu_d;
            rw_q      <= rw_d;
            m2r_q     <= m2r_d;
            alu_q     <= alu_d;
            md_q      <= md_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    // Upstream must not be frozen while the stage itself is held in reset
    assign stall_o = stall & ~rst_i;

    assign mem_if.mem_req_o   = req_q;
    assign mem_if.mem_we_o    = we_q;
    assign mem_if.mem_addr_o  = addr_q;
    assign mem_if.mem_wdata_o = wdata_q;

    assign RegWrite_o  = rw_q;
    assign MemToReg_o  = m2r_q;
    assign ALUResult_o = alu_q;
    assign MemData_o   = md_q;
    assign RDaddr_o    = rd_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases from the stage's intended behaviour
// followed by randomized instruction streams, checked against a transaction-level
// model of what each instruction should retire into MEM/WB.
module tb_mem_access_stage;
    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int W       = 72;

    // clock/reset
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic [31:0] ALUResult_i, RDData_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i, MemToReg_i, MemWrite_i;
    logic        stall_o;
    logic        RegWrite_o, MemToReg_o, err_o;
    logic [31:0] ALUResult_o, MemData_o;
    logic [4:0]  RDaddr_o;

    mem_access_stage_if #(.ADDR_W(ADDR_W)) mem_if ();

    mem_access_stage #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .ALUResult_i (ALUResult_i),
        .RDData_i    (RDData_i),
        .RDaddr_i    (RDaddr_i),
        .RegWrite_i  (RegWrite_i),
        .MemToReg_i  (MemToReg_i),
        .MemWrite_i  (MemWrite_i),
        .stall_o     (stall_o),
        .mem_if      (mem_if),
        .RegWrite_o  (RegWrite_o),
        .MemToReg_o  (MemToReg_o),
        .ALUResult_o (ALUResult_o),
        .MemData_o   (MemData_o),
        .RDaddr_o    (RDaddr_o),
        .err_o       (err_o)
    );

    // scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [W-1:0] exp_q[$];
    logic [31:0] exp_md;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {err_o, RegWrite_o, MemToReg_o, RDaddr_o, ALUResult_o, MemData_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction presented by EX/MEM, held until the stage stops stalling.
    // ack_at: WAIT cycle (1-based) in which the memory acks; > TIMEOUT means never.
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input logic rw,
                             input logic m2r, input logic mw,
                             input int ack_at, input logic [31:0] ack_data);
        logic acc, misal, m2r_eff, done;
        int   stalls, reqs, nexp;
        acc     = m2r | mw;
        misal   = acc && (alu[1:0] != 2'b00);
        m2r_eff = m2r & ~mw;
        ALUResult_i = alu;
        RDData_i    = wd;
        RDaddr_i    = rd;
        RegWrite_i  = rw;
        MemToReg_i  = m2r;
        MemWrite_i  = mw;
        // stray ack while idle must be ignored
        mem_if.mem_ack_i   = 1'($urandom_range(0, 1));
        mem_if.mem_rdata_i = $urandom;
        @(negedge clk);
        chk("idle_stall", W'(stall_o), W'(acc && !misal));
        chk("idle_req", W'(mem_if.mem_req_o), W'(0));
        stalls = stall_o ? 1 : 0;
        reqs   = 0;
        if (!acc || misal) begin
            if (misal) exp_q.push_back({1'b1, 1'b0, 1'b0, rd, alu, exp_md});
            else       exp_q.push_back({1'b0, rw, 1'b0, rd, alu, exp_md});
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TIMEOUT && !done; k++) begin
                step();
                mem_if.mem_ack_i   = (k == ack_at);
                mem_if.mem_rdata_i = (k == ack_at) ? ack_data : $urandom;
                @(negedge clk);
                chk("wait_req", W'(mem_if.mem_req_o), W'(1));
                chk("wait_we", W'(mem_if.mem_we_o), W'(mw));
                chk("wait_addr", W'(mem_if.mem_addr_o), W'({alu[31:2], 2'b00}));
                chk("wait_wdata", W'(mem_if.mem_wdata_o), W'(wd));
                chk("wait_bubble", W'({RegWrite_o, MemToReg_o, err_o}), W'(0));
                chk("wait_stall", W'(stall_o), W'(!(k == ack_at || k == TIMEOUT)));
                if (stall_o) stalls++;
                if (mem_if.mem_req_o) reqs++;
                if (k == ack_at) begin
                    done = 1'b1;
                    if (m2r_eff) exp_md = ack_data;
                    exp_q.push_back({1'b0, rw, m2r_eff, rd, alu, exp_md});
                end else if (k == TIMEOUT) begin
                    done = 1'b1;
                    exp_q.push_back({1'b1, 1'b0, 1'b0, rd, alu, exp_md});
                end
            end
            nexp = (ack_at >= 1 && ack_at <= TIMEOUT) ? ack_at : TIMEOUT;
            chk("stall_cycles", W'(stalls), W'(nexp));
            chk("req_cycles", W'(reqs), W'(nexp));
        end
        step();
        mem_if.mem_ack_i = 1'b0;
        chk("wb_bundle", observed(), exp_q.pop_front());
        chk("req_after", W'(mem_if.mem_req_o), W'(0));
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          kind, r, ack_at;
        rst_i = 1'b1;
        ALUResult_i = '0; RDData_i = '0; RDaddr_i = '0;
        RegWrite_i = 1'b0; MemToReg_i = 1'b0; MemWrite_i = 1'b0;
        mem_if.mem_ack_i = 1'b0; mem_if.mem_rdata_i = '0;
        exp_md = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bundle", observed(), W'(0));
        chk("reset_req", W'(mem_if.mem_req_o), W'(0));
        chk("reset_stall", W'(stall_o), W'(0));
        @(negedge clk);
        rst_i = 1'b0;
        step();

        // directed cases
        run_instr(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        chk("nonmem_alu", W'(ALUResult_o), W'(32'h1234));
        run_instr(32'h0000_0040, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF);
        chk("load_data", W'(MemData_o), W'(32'hDEAD_BEEF));
        run_instr(32'h0000_0080, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1, 32'h1111_1111);
        run_instr(32'h0000_0042, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1, 32'h0);
        chk("misal_err", W'(err_o), W'(1));
        run_instr(32'h0000_0100, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, TIMEOUT + 1, 32'h0);
        run_instr(32'h0000_0104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, TIMEOUT, 32'h1357_9BDF);
        chk("last_ack_no_err", W'(err_o), W'(0));
        run_instr(32'h0000_0200, 32'h5, 5'd12, 1'b1, 1'b1, 1'b1, 2, 32'hFFFF_0000);

        // reset in the middle of a load
        ALUResult_i = 32'h0000_0300; RDaddr_i = 5'd13;
        RegWrite_i = 1'b1; MemToReg_i = 1'b1; MemWrite_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_mid_req", W'(mem_if.mem_req_o), W'(0));
        chk("rst_mid_stall", W'(stall_o), W'(0));
        chk("rst_mid_bundle", observed(), W'(0));
        exp_md = '0;
        @(negedge clk);
        rst_i = 1'b0;
        ALUResult_i = 32'h0000_0077; RDaddr_i = 5'd3;
        RegWrite_i = 1'b1; MemToReg_i = 1'b0; MemWrite_i = 1'b0;
        mem_if.mem_ack_i = 1'b1; mem_if.mem_rdata_i = 32'hCAFE_F00D;
        step();
        mem_if.mem_ack_i = 1'b0;
        chk("late_ack_bundle", observed(), {1'b0, 1'b1, 1'b0, 5'd3, 32'h77, 32'h0});
        chk("late_ack_req", W'(mem_if.mem_req_o), W'(0));

        // randomized stream
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            if (kind != 0 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r < 7)       ack_at = $urandom_range(1, 4);
            else if (r == 7) ack_at = TIMEOUT;
            else             ack_at = TIMEOUT + 1;
            run_instr(a, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      (kind == 1 || kind == 3), (kind == 2 || kind == 3),
                      ack_at, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
